// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch/execute/redirect bundle for branch_predictor (optional stats ports under BP_STATS_EN)
interface branch_predictor_if;
   logic        if_valid;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        ex_valid;
   logic        ex_is_b_type;
   logic [31:0] ex_pc;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic        bp_flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;
`endif

   // Pipeline side: drives lookups and resolutions, consumes predictions and redirects
   modport master (
      output if_valid, if_pc, ex_valid, ex_is_b_type, ex_pc, ex_taken, ex_target,
             ex_pred_taken, ex_pred_target, bp_flush,
      input  pred_taken, pred_target, redirect_valid, redirect_pc
`ifdef BP_STATS_EN
      , input stat_branches, stat_mispredicts
`endif
   );

   // Predictor side
   modport slave (
      input  if_valid, if_pc, ex_valid, ex_is_b_type, ex_pc, ex_taken, ex_target,
             ex_pred_taken, ex_pred_target, bp_flush,
      output pred_taken, pred_target, redirect_valid, redirect_pc
`ifdef BP_STATS_EN
      , output stat_branches, stat_mispredicts
`endif
   );
endinterface

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - 2-bit counter direction table plus tagged BTB with registered mispredict redirect (optional BP_STATS_EN counters)
module branch_predictor #(
   parameter int NUM_ENTRIES = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   branch_predictor_if.slave  bus
);
   localparam int IDX_W = $clog2(NUM_ENTRIES);
   localparam int TAG_W = 30 - IDX_W;

   logic             r_valid  [NUM_ENTRIES];
   logic [TAG_W-1:0] r_tag    [NUM_ENTRIES];
   logic [31:0]      r_target [NUM_ENTRIES];
   logic [1:0]       r_ctr    [NUM_ENTRIES];
   logic             r_redirect_valid;
   logic [31:0]      r_redirect_pc;

   logic [IDX_W-1:0] w_if_idx;
   logic [TAG_W-1:0] w_if_tag;
   logic             w_if_hit;
   logic             w_if_taken;
   logic [31:0]      w_if_seq;
   logic [IDX_W-1:0] w_ex_idx;
   logic [TAG_W-1:0] w_ex_tag;
   logic             w_ex_hit;
   logic             w_update;
   logic             w_mispredict;
   logic [31:0]      w_ex_seq;

   assign w_if_idx   = bus.if_pc[IDX_W+1:2];
   assign w_if_tag   = bus.if_pc[31:IDX_W+2];
   assign w_if_hit   = bus.if_valid & r_valid[w_if_idx] & (r_tag[w_if_idx] == w_if_tag);
   assign w_if_taken = w_if_hit & r_ctr[w_if_idx][1];
   assign w_if_seq   = bus.if_pc + 32'd4;

   // Lookup reads the pre-edge table only; a same-cycle update is not bypassed
   assign bus.pred_taken  = w_if_taken;
   assign bus.pred_target = w_if_taken ? r_target[w_if_idx] : w_if_seq;

   assign w_ex_idx = bus.ex_pc[IDX_W+1:2];
   assign w_ex_tag = bus.ex_pc[31:IDX_W+2];
   assign w_ex_hit = r_valid[w_ex_idx] & (r_tag[w_ex_idx] == w_ex_tag);
   assign w_update = bus.ex_valid & bus.ex_is_b_type;
   assign w_ex_seq = bus.ex_pc + 32'd4;

   // A wrong direction, or a taken/taken pair with a stale target, both need a redirect
   assign w_mispredict = w_update &
                         ((bus.ex_taken != bus.ex_pred_taken) |
                          (bus.ex_taken & bus.ex_pred_taken & (bus.ex_target != bus.ex_pred_target)));

   // Train the tables; flush clears valid bits and takes priority over a same-cycle update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_ctr[i]    <= 2'd0;
         end
      end else if (bus.bp_flush) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            r_valid[i] <= 1'b0;
         end
      end else if (w_update) begin
         if (w_ex_hit) begin
            if (bus.ex_taken) begin
               if (r_ctr[w_ex_idx] != 2'd3) begin
                  r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
               end
               r_target[w_ex_idx] <= bus.ex_target;
            end else if (r_ctr[w_ex_idx] != 2'd0) begin
               r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
            end
         end else if (bus.ex_taken) begin
            r_valid[w_ex_idx]  <= 1'b1;
            r_tag[w_ex_idx]    <= w_ex_tag;
            r_target[w_ex_idx] <= bus.ex_target;
            r_ctr[w_ex_idx]    <= 2'd2;
         end
      end
   end

   // One-cycle redirect pulse per mispredict; the corrected PC is held between mispredicts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= 32'd0;
      end else begin
         r_redirect_valid <= w_mispredict;
         if (w_mispredict) begin
            r_redirect_pc <= bus.ex_taken ? bus.ex_target : w_ex_seq;
         end
      end
   end

   assign bus.redirect_valid = r_redirect_valid;
   assign bus.redirect_pc    = r_redirect_pc;

`ifdef BP_STATS_EN
   logic [31:0] r_stat_branches;
   logic [31:0] r_stat_mispredicts;

   // Free-running event counters, unaffected by flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stat_branches    <= 32'd0;
         r_stat_mispredicts <= 32'd0;
      end else begin
         if (w_update) begin
            r_stat_branches <= r_stat_branches + 32'd1;
         end
         if (w_mispredict) begin
            r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
         end
      end
   end

   assign bus.stat_branches    = r_stat_branches;
   assign bus.stat_mispredicts = r_stat_mispredicts;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard bench for branch_predictor against a table-level reference model
module tb_branch_predictor;
   localparam int N = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   branch_predictor_if bus ();

   branch_predictor #(.NUM_ENTRIES(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int failures = 0;

   // Reference model: one record per table slot, addressed by plain arithmetic
   bit          m_valid  [N];
   logic [31:0] m_tag    [N];
   logic [31:0] m_target [N];
   int          m_ctr    [N];
   logic [31:0] m_redirect_pc;
   logic [31:0] m_branches;
   logic [31:0] m_mispredicts;

   typedef struct { logic taken; logic [31:0] target; logic [31:0] pc; } pred_t;
   typedef struct { logic valid; logic [31:0] pc; } redir_t;
   pred_t  pred_q  [$];
   redir_t redir_q [$];
   bit     mon_en = 0;
   bit     have_prev = 0;
   redir_t prev_exp;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         m_valid[i]  = 0;
         m_tag[i]    = 32'd0;
         m_target[i] = 32'd0;
         m_ctr[i]    = 0;
      end
      m_redirect_pc = 32'd0;
      m_branches    = 32'd0;
      m_mispredicts = 32'd0;
   endfunction

   function automatic void model_predict(input logic v, input logic [31:0] pc,
                                         output logic t, output logic [31:0] tg);
      int idx;
      logic [31:0] tag;
      idx = int'((pc / 4) % N);
      tag = pc / (4 * N);
      t   = v && m_valid[idx] && (m_tag[idx] == tag) && (m_ctr[idx] >= 2);
      tg  = t ? m_target[idx] : pc + 32'd4;
   endfunction

   // Apply one cycle of stimulus, queue the expected responses, advance the model
   task automatic drive(input logic iv, input logic [31:0] ipc,
                        input logic ev, input logic eb, input logic [31:0] epc,
                        input logic et, input logic [31:0] etg,
                        input logic ept, input logic [31:0] eptg, input logic fl);
      pred_t  p;
      redir_t r;
      logic   mp;
      int     idx;
      logic [31:0] tag;
      bus.if_valid = iv;  bus.if_pc = ipc;
      bus.ex_valid = ev;  bus.ex_is_b_type = eb; bus.ex_pc = epc;
      bus.ex_taken = et;  bus.ex_target = etg;
      bus.ex_pred_taken = ept; bus.ex_pred_target = eptg;
      bus.bp_flush = fl;
      model_predict(iv, ipc, p.taken, p.target);
      p.pc = ipc;
      pred_q.push_back(p);
      mp = ev && eb && ((et != ept) || (et && ept && (etg != eptg)));
      if (mp) m_redirect_pc = et ? etg : epc + 32'd4;
      r.valid = mp;
      r.pc    = m_redirect_pc;
      redir_q.push_back(r);
      if (ev && eb) m_branches = m_branches + 32'd1;
      if (mp) m_mispredicts = m_mispredicts + 32'd1;
      idx = int'((epc / 4) % N);
      tag = epc / (4 * N);
      if (fl) begin
         for (int i = 0; i < N; i++) m_valid[i] = 0;
      end else if (ev && eb) begin
         if (m_valid[idx] && m_tag[idx] == tag) begin
            if (et) begin
               if (m_ctr[idx] < 3) m_ctr[idx]++;
               m_target[idx] = etg;
            end else if (m_ctr[idx] > 0) begin
               m_ctr[idx]--;
            end
         end else if (et) begin
            m_valid[idx]  = 1;
            m_tag[idx]    = tag;
            m_target[idx] = etg;
            m_ctr[idx]    = 2;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic lookup(input logic [31:0] pc);
      drive(1'b1, pc, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
   endtask

   task automatic resolve(input logic [31:0] ipc, input logic [31:0] epc, input logic et,
                          input logic [31:0] etg, input logic ept, input logic [31:0] eptg);
      drive(1'b1, ipc, 1'b1, 1'b1, epc, et, etg, ept, eptg, 1'b0);
   endtask

   // Monitor: compare the prediction of this cycle and the redirect produced by the previous one
   always @(negedge clk) begin
      if (mon_en) begin
         if (pred_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL pred_queue_empty actual=0 expected=1");
         end else begin
            pred_t p;
            p = pred_q.pop_front();
            check32("pred_taken", {31'd0, bus.pred_taken}, {31'd0, p.taken});
            check32("pred_target", bus.pred_target, p.target);
         end
         if (have_prev) begin
            check32("redirect_valid", {31'd0, bus.redirect_valid}, {31'd0, prev_exp.valid});
            check32("redirect_pc", bus.redirect_pc, prev_exp.pc);
         end
         if (redir_q.size() > 0) begin
            prev_exp  = redir_q.pop_front();
            have_prev = 1;
         end
      end
   end

   function automatic logic [31:0] rand_pc();
      if ($urandom_range(0, 9) == 0) return 32'hFFFF_FFFC;
      return 32'($urandom_range(0, 3) * N * 4 + $urandom_range(0, 7) * 4);
   endfunction

   function automatic logic [31:0] rand_target();
      case ($urandom_range(0, 3))
         0: return 32'h0000_0080;
         1: return 32'h0000_0400;
         2: return 32'h0000_0FFC;
         default: return {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      endcase
   endfunction

   initial begin
      logic        pt;
      logic [31:0] ptg;
      logic [31:0] epc;
      model_reset();
      bus.if_valid = 1'b1; bus.if_pc = 32'h0000_0100;
      bus.ex_valid = 1'b0; bus.ex_is_b_type = 1'b0; bus.ex_pc = 32'd0;
      bus.ex_taken = 1'b0; bus.ex_target = 32'd0;
      bus.ex_pred_taken = 1'b0; bus.ex_pred_target = 32'd0; bus.bp_flush = 1'b0;
      #3;
      check32("reset_pred_taken", {31'd0, bus.pred_taken}, 32'd0);
      check32("reset_pred_target", bus.pred_target, 32'h0000_0104);
      check32("reset_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
      check32("reset_redirect_pc", bus.redirect_pc, 32'd0);
      #9 rst_n = 1'b1;
      @(posedge clk); #1;
      mon_en = 1;

      // Directed: allocate, same-cycle lookup sees old state, then train down
      lookup(32'h100);
      resolve(32'h100, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
      lookup(32'h100);
      resolve(32'h100, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
      resolve(32'h100, 32'h100, 1'b0, 32'h80, 1'b0, 32'h0);
      lookup(32'h100);
      // Wrong target with correct direction
      resolve(32'h100, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
      resolve(32'h100, 32'h100, 1'b1, 32'h180, 1'b1, 32'h80);
      lookup(32'h100);
      // Aliasing overwrite
      resolve(32'h100, 32'h100 + 4 * N, 1'b1, 32'h500, 1'b0, 32'h0);
      lookup(32'h100);
      lookup(32'h100 + 4 * N);
      // Flush with simultaneous update
      drive(1'b1, 32'h140, 1'b1, 1'b1, 32'h140, 1'b1, 32'h90, 1'b0, 32'h0, 1'b1);
      lookup(32'h140);
      lookup(32'h100 + 4 * N);
      // Address wrap and if_valid low on a hitting entry
      lookup(32'hFFFF_FFFC);
      resolve(32'h0, 32'hFFFF_FFFC, 1'b1, 32'h40, 1'b0, 32'h0);
      resolve(32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 32'h40, 1'b1, 32'h40);
      drive(1'b0, 32'h200, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      // Non-branch resolution is ignored
      drive(1'b1, 32'h300, 1'b1, 1'b0, 32'h300, 1'b1, 32'h600, 1'b0, 32'h0, 1'b0);
      lookup(32'h300);

      // Reset asserted with a redirect pending
      lookup(32'h0);
      mon_en = 0;
      bus.if_valid = 1'b0;
      bus.ex_valid = 1'b1; bus.ex_is_b_type = 1'b1; bus.ex_pc = 32'h40;
      bus.ex_taken = 1'b1; bus.ex_target = 32'h300; bus.ex_pred_taken = 1'b0;
      bus.ex_pred_target = 32'h0; bus.bp_flush = 1'b0;
      @(posedge clk); #1;
      check32("pre_reset_redirect_valid", {31'd0, bus.redirect_valid}, 32'd1);
      check32("pre_reset_redirect_pc", bus.redirect_pc, 32'h300);
      bus.ex_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check32("midreset_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
      check32("midreset_redirect_pc", bus.redirect_pc, 32'd0);
      bus.if_valid = 1'b1; bus.if_pc = 32'h40;
      #1;
      check32("midreset_pred_taken", {31'd0, bus.pred_taken}, 32'd0);
      check32("midreset_pred_target", bus.pred_target, 32'h44);
      #2 rst_n = 1'b1;
      model_reset();
      @(posedge clk); #1;
      pred_q.delete();
      redir_q.delete();
      have_prev = 0;
      mon_en = 1;

      // Five branches with two mispredicts interleaved with three non-branches
      resolve(32'h10, 32'h10, 1'b1, 32'h80, 1'b0, 32'h0);
      drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
      resolve(32'h10, 32'h10, 1'b1, 32'h80, 1'b1, 32'h80);
      resolve(32'h10, 32'h10, 1'b0, 32'h80, 1'b0, 32'h0);
      drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h24, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
      resolve(32'h10, 32'h10, 1'b0, 32'h80, 1'b1, 32'h80);
      drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h28, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
      resolve(32'h10, 32'h10, 1'b1, 32'h80, 1'b1, 32'h80);
`ifdef BP_STATS_EN
      check32("stat_branches_plan", bus.stat_branches, 32'd5);
      check32("stat_mispredicts_plan", bus.stat_mispredicts, 32'd2);
`endif

      // Randomized traffic over a small aliasing address set
      for (int n = 0; n < 600; n++) begin
         epc = rand_pc();
         model_predict(1'b1, epc, pt, ptg);
         if ($urandom_range(0, 1) == 0) begin
            pt  = logic'($urandom_range(0, 1));
            ptg = rand_target();
         end
         drive(logic'($urandom_range(0, 4) != 0), rand_pc(),
               logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 4) != 0), epc,
               logic'($urandom_range(0, 1)), rand_target(), pt, ptg,
               logic'($urandom_range(0, 29) == 0));
      end
`ifdef BP_STATS_EN
      check32("stat_branches_final", bus.stat_branches, m_branches);
      check32("stat_mispredicts_final", bus.stat_mispredicts, m_mispredicts);
`endif
      lookup(32'h0);
      mon_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side branch predictor: a direct-mapped table of 2-bit saturating direction counters plus a tagged branch target buffer (BTB).
- Fetch gets a same-cycle prediction for the current PC.
- Execute returns the resolved outcome from branch_control (branch_taken) and the computed target.
- Each resolution trains the tables and raises a registered one-cycle redirect on misprediction.

Parameters:
- NUM_ENTRIES, 64, table depth; power of two, minimum 4.
- IDX_W, $clog2(NUM_ENTRIES), index width; derived, never overridden.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- if_valid  input  1  fetch lookup valid.
- if_pc  input  32  fetch PC, word aligned.
- pred_taken  output  1  predicted taken; combinational from if_pc and table state.
- pred_target  output  32  predicted next PC; combinational.
- ex_valid  input  1  resolution valid.
- ex_is_b_type  input  1  resolved instruction is a conditional branch.
- ex_pc  input  32  PC of the resolved branch.
- ex_taken  input  1  actual outcome (branch_control branch_taken).
- ex_target  input  32  actual branch target (pc + B-immediate).
- ex_pred_taken  input  1  prediction carried down the pipe with the branch.
- ex_pred_target  input  32  predicted target carried down the pipe.
- bp_flush  input  1  synchronous invalidate of all BTB entries.
- redirect_valid  output  1  misprediction redirect, registered.
- redirect_pc  output  32  corrected fetch PC, registered.

Behaviour:
- Address fields:
  - idx = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2].
  - Each entry holds valid, tag, target[31:0] and ctr[1:0].
- Reset (async, rst_n low):
  - All valid and ctr bits = 0; redirect_valid = 0; redirect_pc = 0.
  - pred_taken = 0 and pred_target = if_pc + 4 then follow from the cleared tables.
- Lookup (combinational, zero latency):
  - hit = if_valid & valid[idx] & (tag matches).
  - pred_taken = hit & ctr[idx][1].
  - pred_target = pred_taken ? target[idx] : if_pc + 4, using modulo-2^32 wrap; if_pc 0xFFFFFFFC gives 0x00000000.
  - When if_valid = 0: pred_taken = 0 and pred_target = if_pc + 4.
- Update: applies at clk edge when ex_valid & ex_is_b_type. Non-branch resolutions are ignored entirely.
  - Entry present (valid & tag match):
    - ctr saturating: taken increments, capped at 3; not-taken decrements, floored at 0.
    - If taken, target is written with ex_target.
  - Entry absent and ex_taken = 1: allocate or overwrite. Set valid = 1, tag, target = ex_target, ctr = 2 (weakly taken).
  - Entry absent and ex_taken = 0: no table change.
- Mispredict:
  - mp = ex_valid & ex_is_b_type & ((ex_taken != ex_pred_taken) | (ex_taken & ex_pred_taken & ex_target != ex_pred_target)).
  - At the next edge: redirect_valid <= mp; redirect_pc <= ex_taken ? ex_target : ex_pc + 4 (wrap mod 2^32).
  - redirect_pc updates only when mp = 1 and holds its value otherwise.
  - redirect_valid is a one-cycle pulse per mispredicting resolution; back-to-back mispredictions give consecutive pulses.
- Simultaneous events:
  - A lookup and an update to the same idx in the same cycle: the lookup sees pre-update state. No write-through bypass.
  - bp_flush and an update in the same cycle: the flush wins; all valid bits are 0 after the edge, ctr values are untouched.
  - Misprediction detection is unaffected by flush.
- Reset asserted mid-operation: all state clears immediately; any pending redirect is dropped.

Optional Feature:
- Macro BP_STATS_EN.
- When defined, adds two outputs:
  - stat_branches  output  32: count of resolved conditional branches.
  - stat_mispredicts  output  32: count of cycles where mp = 1.
- Both counters reset to 0, wrap at 2^32 and ignore bp_flush.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then lookup if_pc=0x00000100 → pred_taken=0, pred_target=0x00000104; redirect_valid=0.
- Resolve ex_pc=0x100, taken, ex_target=0x80, ex_pred_taken=0 → next cycle redirect_valid=1, redirect_pc=0x80. Then lookup 0x100 → pred_taken=1, pred_target=0x80.
- Training from the previous state: resolve 0x100 not-taken twice → ctr goes 2→1→0. Lookup then gives pred_taken=0; the first not-taken with ex_pred_taken=1 redirects to 0x104.
- Aliasing: entry at 0x100 plus a taken resolution at 0x100 + 4*NUM_ENTRIES (0x200 for 64 entries) → entry overwritten; lookup 0x100 misses, pred_target=0x104.
- Same-cycle lookup and update on 0x100 → lookup returns old prediction; the following cycle returns the new one. bp_flush with an update in the same cycle → every lookup misses.
- BP_STATS_EN: 5 branch resolutions with 2 mispredicts plus 3 non-branch ex_valid → stat_branches=5, stat_mispredicts=2.
